// File: rtl/canny_window_ctrl.sv
// canny_window_ctrl: pops raster pixels, drives line-buffer shift and flags interior 3x3 windows
module canny_window_ctrl #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          out_ready,
  output logic          lb_shift,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d, tr_q, tr_d, win_row_q, win_row_d;
  logic [CW-1:0] col_q, col_d, tc_q, tc_d, win_col_q, win_col_d;
  logic          dc_q, dc_d, sh_q, sh_d, wv_q, wv_d, fd_q, fd_d;
  logic          go, last;
  always_comb begin
    fifo_rd_en = state_q == RUN && !fifo_empty && out_ready;
    go = state_q == IDLE && start && !fd_q;
    last = fifo_rd_en && row_q == LAST_R && col_q == LAST_C;
    state_d = state_q == IDLE ? (go ? RUN : IDLE) :
              state_q == RUN  ? (last ? DRAIN : RUN) :
                                (dc_q ? IDLE : DRAIN);
    dc_d = state_q == DRAIN && !dc_q;
    fd_d = state_q == DRAIN && dc_q;
    col_d = go ? '0 : fifo_rd_en ? (col_q == LAST_C ? '0 : col_q + CW'(1)) : col_q;
    row_d = go ? '0 : (fifo_rd_en && col_q == LAST_C) ? row_q + RW'(1) : row_q;
    sh_d = fifo_rd_en;
    tr_d = fifo_rd_en ? row_q : tr_q;
    tc_d = fifo_rd_en ? col_q : tc_q;
    wv_d = sh_q && tr_q >= RW'(2) && tc_q >= CW'(2);
    win_row_d = wv_d ? tr_q - RW'(1) : win_row_q;
    win_col_d = wv_d ? tc_q - CW'(1) : win_col_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      tr_q <= '0;
      tc_q <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      dc_q <= 1'b0;
      sh_q <= 1'b0;
      wv_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      tr_q <= tr_d;
      tc_q <= tc_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      dc_q <= dc_d;
      sh_q <= sh_d;
      wv_q <= wv_d;
      fd_q <= fd_d;
    end
  end
  assign lb_shift = sh_q;
  assign win_valid = wv_q;
  assign win_row = win_row_q;
  assign win_col = win_col_q;
  assign busy = state_q != IDLE;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_canny_window_ctrl.sv
// tb_canny_window_ctrl: random and directed frames checked against a pop-history reference model
module tb_canny_window_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, fifo_empty = 1'b1, out_ready = 1'b1;
  logic fifo_rd_en, lb_shift, win_valid, busy, frame_done;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  int errors = 0, checks = 0, t = 10;
  int n_win, n_sh, n_fd;
  bit m_busy;
  int m_k, m_last;
  bit pv[4];
  int pidx[4];
  canny_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .out_ready(out_ready), .lb_shift(lb_shift),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 1'b0;
    m_k = 0;
    m_last = -100;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pidx[i] = 0;
    end
  endtask
  task automatic cyc(bit s, bit e, bit r);
    int k;
    bit erd, ewv;
    @(negedge clk);
    start = s;
    fifo_empty = e;
    out_ready = r;
    #1;
    erd = m_busy && m_k < W * H && !e && r;
    k = pidx[(t - 2) % 4];
    ewv = pv[(t - 2) % 4] && k / W >= 2 && k % W >= 2;
    check("rd_en", fifo_rd_en, erd);
    check("lb_shift", lb_shift, pv[(t - 1) % 4]);
    check("win_valid", win_valid, ewv);
    if (ewv) begin
      check("win_row", win_row, k / W - 1);
      check("win_col", win_col, k % W - 1);
    end
    check("busy", busy, m_busy);
    check("frame_done", frame_done, t == m_last + 3);
    n_win += win_valid;
    n_sh += lb_shift;
    n_fd += frame_done;
    pv[t % 4] = erd;
    pidx[t % 4] = m_k;
    if (erd) begin
      m_k++;
      if (m_k == W * H) m_last = t;
    end
    if (m_busy && t == m_last + 2) m_busy = 1'b0;
    else if (!m_busy && s && t != m_last + 3) begin
      m_busy = 1'b1;
      m_k = 0;
    end
    t++;
  endtask
  task automatic run_frame(int mode);
    bit s, e, r;
    n_win = 0;
    n_sh = 0;
    n_fd = 0;
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300 && n_fd == 0; i++) begin
      s = mode == 5 || (mode == 4 && i == 4);
      e = mode == 1 ? i[0] : mode == 3 ? ($urandom_range(0, 3) == 0) : 1'b0;
      r = mode == 2 ? !(i >= 5 && i < 10) : mode == 3 ? ($urandom_range(0, 4) != 0) : 1'b1;
      cyc(s, e, r);
    end
    check("frame_done_count", n_fd, 1);
    check("window_count", n_win, (H - 2) * (W - 2));
    check("shift_count", n_sh, W * H);
  endtask
  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(4);
    repeat (4) run_frame(3);
    run_frame(5);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50 && m_k < 7; i++) cyc(1'b0, 1'b0, 1'b1);
    check("pops_before_reset", m_k, 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_lb_shift", lb_shift, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    model_reset();
    cyc(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    run_frame(0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
